stack_ctrl: RTL and testbench
=============================

# stack_ctrl

Multicycle control unit for the 8-bit stack-machine datapath with a 5-bit PC, 32×8 unified memory, 1024-deep stack, A register, MEM register and 2-bit ALU. It holds a state register and fetches, decodes and executes one instruction at a time. It takes the instruction opcode and the PC-select feedback from the datapath and drives every datapath strobe and mux select. It also drives a one-cycle retire pulse and a state code for the bench.

## Interface
Parameters:
- none; encodings come from `stack_ctrl_pkg`.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- run  in  1  permit fetch of next instruction; sampled only in FETCH
- opcode  in  3  IR[7:5]; valid from DECODE until the instruction retires
- pc_sel  in  1  datapath `(zero & cn_pc_ds) | pc_dst`
- ld_pc, pc_dst, cn_pc_ds, adrr, write, ld_inst  out  1 each  datapath strobes/selects
- push, pop, tos, st_data, ld_a, ld_mem, alu_src_a  out  1 each  datapath strobes/selects
- alu_src_b  out  2  11=0x00, 10=0xFF, 01=0x01, 00=stack d_out
- alu_ctrl  out  2  00 A+B, 01 B−A, 10 A&B
- retire  out  1  high in the final cycle of each instruction
- state  out  4  current state code, debug only

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH addr, 101 POP addr, 110 JMP addr, 111 JZ addr. `addr` is IR[4:0].
- Every output not listed for a state is 0.
- FETCH, run=1:
  - adrr=1, ld_inst=1.
  - alu_src_a=1, alu_src_b=01, alu_ctrl=00, ld_pc=1, so PC ← PC+1.
  - Next state DECODE.
- FETCH, run=0: all strobes 0; stay in FETCH.
- DECODE: no strobes. Dispatch on opcode.
- ADD/SUB/AND: POP1 (pop) → POP2 (pop, ld_a) → EXEC.
  - EXEC: alu_src_a=0, alu_src_b=00, st_data=0, push=1.
  - alu_ctrl: 00 for ADD, 01 for SUB, 10 for AND.
  - SUB result = second-popped − first-popped.
- NOT: POP1 (pop) → LDA (ld_a) → EXEC.
  - EXEC: alu_src_a=0, alu_src_b=10, alu_ctrl=01, push=1, giving 0xFF−A = ~A.
- PUSH: MRD (adrr=0, ld_mem=1) → PWB (st_data=1, push=1).
- POP: POP1 (pop) → MWR (adrr=0, write=1). Memory[addr] ← popped value.
- JMP: JMP (pc_dst=1, ld_pc=1). PC ← addr.
- JZ: TOS (tos) → LDA (ld_a) → JZX.
  - JZX: alu_src_a=0, alu_src_b=11, alu_ctrl=00, cn_pc_ds=1, ld_pc=pc_sel.
  - Taken when the top of stack = 0: PC ← addr.
  - Not taken: PC unchanged.
  - JZ never pops.
- Return to FETCH: the last state of each instruction asserts retire and then goes to FETCH.
  - Last states: EXEC, PWB, MWR, JMP, JZX.
- No stack full/empty checking; pointer wrap is the datapath's behaviour.

## Timing
- Cycles per instruction:
  - ADD/SUB/AND/NOT/JZ: 5.
  - PUSH/POP: 4.
  - JMP: 3.
- All outputs are Moore decodes of state and opcode, except ld_pc in JZX, which is Mealy on pc_sel (same cycle).
- The stack d_out is registered, so a pop or tos in cycle N feeds ld_a or write in cycle N+1. This is why POP2, LDA and MWR each follow a pop/tos state.
- While rst is high: state = FETCH and every output = 0, including retire and state = 0. The first fetch happens on the first rising edge after rst falls with run=1.
- rst mid-instruction aborts it: the pending push/write is not issued and no retire pulse occurs.
- run deasserted mid-instruction has no effect until the next FETCH.
- An undefined state code goes to FETCH.

## Structure
- `stack_ctrl_pkg` holds:
  - opcode constants.
  - alu_ctrl and alu_src_b encodings.
  - the state enum (4-bit): FETCH, DECODE, POP1, POP2, LDA, EXEC, MRD, PWB, MWR, JMP, TOS, JZX.
- The block is one module: a state register plus a combinational next-state/output decode. No sub-module.
- A top `stack_cpu` instantiates `stack_ctrl` and the datapath; benches drive that top.

## Test plan
- Program push 6, push 8, ADD, push 3, push 6, ADD, SUB, with run held high from reset → stack top = 0x05. Retire pulses at cycles 4, 8, 13, 17, 21, 26, 31.
- push 0x06, NOT, POP 20 → memory[20] = 0xF9; stack pointer back to its start value.
- push 0x00, JZ 10 → PC = 10 after JZX; the stack still holds 0x00.
- push 0x04, JZ 10 → ld_pc stays low in JZX; PC = address of the JZ + 1.
- run=0 after reset for 10 cycles → state stays FETCH, all strobes 0, PC = 0. Raising run starts the fetch on the next edge.
- rst pulsed in the EXEC cycle of ADD → outputs go 0 immediately, no push, state = FETCH. Re-execution from PC 0 after release is correct.

Source files
------------

// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the stack-machine control unit: opcodes, ALU selects,
// state codes and the bundle of datapath control strobes.
package stack_ctrl_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;  // A + B
  localparam logic [1:0] ALU_SUB = 2'b01;  // B - A
  localparam logic [1:0] ALU_AND = 2'b10;  // A & B

  localparam logic [1:0] SRC_B_STACK = 2'b00;
  localparam logic [1:0] SRC_B_ONE   = 2'b01;
  localparam logic [1:0] SRC_B_FF    = 2'b10;
  localparam logic [1:0] SRC_B_ZERO  = 2'b11;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    POP1   = 4'd2,
    POP2   = 4'd3,
    LDA    = 4'd4,
    EXEC   = 4'd5,
    MRD    = 4'd6,
    PWB    = 4'd7,
    MWR    = 4'd8,
    JMP    = 4'd9,
    TOS    = 4'd10,
    JZX    = 4'd11
  } state_e;

  typedef struct packed {
    logic       ld_pc;
    logic       pc_dst;
    logic       cn_pc_ds;
    logic       adrr;
    logic       write;
    logic       ld_inst;
    logic       push;
    logic       pop;
    logic       tos;
    logic       st_data;
    logic       ld_a;
    logic       ld_mem;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctrl;
    logic       retire;
  } ctrl_t;

  // Two-operand ALU instructions map straight onto an ALU function.
  function automatic logic [1:0] alu_ctrl_for(input logic [2:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Multicycle control unit for the 8-bit stack machine: a state register and a
// combinational next-state / strobe decode, one instruction at a time.
module stack_ctrl
  import stack_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [2:0] opcode,
  input  logic       pc_sel,
  output logic       ld_pc,
  output logic       pc_dst,
  output logic       cn_pc_ds,
  output logic       adrr,
  output logic       write,
  output logic       ld_inst,
  output logic       push,
  output logic       pop,
  output logic       tos,
  output logic       st_data,
  output logic       ld_a,
  output logic       ld_mem,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_ctrl,
  output logic       retire,
  output logic [3:0] state
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  ctrl_t  ctrl_out;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      FETCH: begin
        if (run) begin
          ctrl.adrr      = 1'b1;
          ctrl.ld_inst   = 1'b1;
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRC_B_ONE;
          ctrl.alu_ctrl  = ALU_ADD;
          ctrl.ld_pc     = 1'b1;
          state_d        = DECODE;
        end
      end

      DECODE: begin
        case (opcode)
          OP_PUSH: state_d = MRD;
          OP_JMP:  state_d = JMP;
          OP_JZ:   state_d = TOS;
          default: state_d = POP1;  // ADD/SUB/AND/NOT/POP all start with a pop
        endcase
      end

      POP1: begin
        ctrl.pop = 1'b1;
        case (opcode)
          OP_ADD, OP_SUB, OP_AND: state_d = POP2;
          OP_NOT:                 state_d = LDA;
          OP_POP:                 state_d = MWR;
          default:                state_d = FETCH;
        endcase
      end

      // The registered stack output from POP1 is captured into A while the
      // second operand is popped into the stack output register.
      POP2: begin
        ctrl.pop  = 1'b1;
        ctrl.ld_a = 1'b1;
        state_d   = EXEC;
      end

      LDA: begin
        ctrl.ld_a = 1'b1;
        case (opcode)
          OP_NOT:  state_d = EXEC;
          OP_JZ:   state_d = JZX;
          default: state_d = FETCH;
        endcase
      end

      EXEC: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.st_data   = 1'b0;
        ctrl.push      = 1'b1;
        ctrl.retire    = 1'b1;
        if (opcode == OP_NOT) begin
          ctrl.alu_src_b = SRC_B_FF;  // 0xFF - A is the bitwise complement
          ctrl.alu_ctrl  = ALU_SUB;
        end else begin
          ctrl.alu_src_b = SRC_B_STACK;
          ctrl.alu_ctrl  = alu_ctrl_for(opcode);
        end
        state_d = FETCH;
      end

      MRD: begin
        ctrl.adrr   = 1'b0;
        ctrl.ld_mem = 1'b1;
        state_d     = PWB;
      end

      PWB: begin
        ctrl.st_data = 1'b1;
        ctrl.push    = 1'b1;
        ctrl.retire  = 1'b1;
        state_d      = FETCH;
      end

      MWR: begin
        ctrl.adrr   = 1'b0;
        ctrl.write  = 1'b1;
        ctrl.retire = 1'b1;
        state_d     = FETCH;
      end

      JMP: begin
        ctrl.pc_dst = 1'b1;
        ctrl.ld_pc  = 1'b1;
        ctrl.retire = 1'b1;
        state_d     = FETCH;
      end

      TOS: begin
        ctrl.tos = 1'b1;
        state_d  = LDA;
      end

      // A passes through the ALU unchanged; the datapath's zero flag then
      // decides pc_sel, which loads the PC in this same cycle.
      JZX: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRC_B_ZERO;
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.cn_pc_ds  = 1'b1;
        ctrl.ld_pc     = pc_sel;
        ctrl.retire    = 1'b1;
        state_d        = FETCH;
      end

      default: state_d = FETCH;
    endcase
  end

  // Reset forces every output low at once, aborting any pending push/write.
  assign ctrl_out = rst ? '0 : ctrl;
  assign state    = rst ? 4'd0 : state_q;

  assign ld_pc     = ctrl_out.ld_pc;
  assign pc_dst    = ctrl_out.pc_dst;
  assign cn_pc_ds  = ctrl_out.cn_pc_ds;
  assign adrr      = ctrl_out.adrr;
  assign write     = ctrl_out.write;
  assign ld_inst   = ctrl_out.ld_inst;
  assign push      = ctrl_out.push;
  assign pop       = ctrl_out.pop;
  assign tos       = ctrl_out.tos;
  assign st_data   = ctrl_out.st_data;
  assign ld_a      = ctrl_out.ld_a;
  assign ld_mem    = ctrl_out.ld_mem;
  assign alu_src_a = ctrl_out.alu_src_a;
  assign alu_src_b = ctrl_out.alu_src_b;
  assign alu_ctrl  = ctrl_out.alu_ctrl;
  assign retire    = ctrl_out.retire;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: drives a behavioural datapath from the controller and
// compares each retired instruction against an instruction-level model.
module tb_stack_ctrl;
  import stack_ctrl_pkg::*;

  typedef logic [7:0] mem_t [32];

  typedef struct {
    logic [2:0] op;
    int         len;
    logic [4:0] pc;
    logic [9:0] sp;
    logic [7:0] tos_v;
    int         sig;
    bit         taken;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic [2:0] opcode;
  logic pc_sel;
  logic ld_pc, pc_dst, cn_pc_ds, adrr, write, ld_inst, push, pop, tos;
  logic st_data, ld_a, ld_mem, alu_src_a, retire;
  logic [1:0] alu_src_b, alu_ctrl;
  logic [3:0] state;

  int vecs = 0;
  int miscompares = 0;

  stack_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .pc_sel(pc_sel),
    .ld_pc(ld_pc), .pc_dst(pc_dst), .cn_pc_ds(cn_pc_ds), .adrr(adrr),
    .write(write), .ld_inst(ld_inst), .push(push), .pop(pop), .tos(tos),
    .st_data(st_data), .ld_a(ld_a), .ld_mem(ld_mem), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .retire(retire), .state(state)
  );

  always #5 clk = ~clk;

  logic [21:0] outs;
  assign outs = {ld_pc, pc_dst, cn_pc_ds, adrr, write, ld_inst, push, pop, tos,
                 st_data, ld_a, ld_mem, alu_src_a, alu_src_b, alu_ctrl, retire, state};

  // ---------------- behavioural datapath ----------------
  mem_t       image;
  mem_t       dp_mem;
  logic [7:0] dp_stk [1024];
  logic [4:0] dp_pc;
  logic [9:0] dp_sp;
  logic [7:0] dp_ir, dp_a, dp_mreg, dp_dout;
  logic       load_req = 1'b0;
  int         cyc;
  logic [7:0] alu_a, alu_b, alu_y;

  always_comb begin
    alu_a = alu_src_a ? {3'b000, dp_pc} : dp_a;
    case (alu_src_b)
      2'b11:   alu_b = 8'h00;
      2'b10:   alu_b = 8'hFF;
      2'b01:   alu_b = 8'h01;
      default: alu_b = dp_dout;
    endcase
    case (alu_ctrl)
      2'b00:   alu_y = alu_a + alu_b;
      2'b01:   alu_y = alu_b - alu_a;
      2'b10:   alu_y = alu_a & alu_b;
      default: alu_y = 8'h00;
    endcase
  end

  assign pc_sel = ((alu_y == 8'h00) & cn_pc_ds) | pc_dst;
  assign opcode = dp_ir[7:5];

  always @(posedge clk) begin
    if (load_req) begin
      dp_mem <= image;
      for (int i = 0; i < 1024; i++) dp_stk[i] <= 8'h00;
    end else begin
      if (push)  dp_stk[dp_sp] <= st_data ? dp_mreg : alu_y;
      if (write) dp_mem[dp_ir[4:0]] <= dp_dout;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_pc <= '0; dp_sp <= '0; dp_ir <= '0; dp_a <= '0;
      dp_mreg <= '0; dp_dout <= '0; cyc <= 0;
    end else begin
      cyc <= cyc + 1;
      if (ld_pc)   dp_pc   <= pc_sel ? dp_ir[4:0] : alu_y[4:0];
      if (ld_inst) dp_ir   <= dp_mem[dp_pc];
      if (ld_mem)  dp_mreg <= dp_mem[dp_ir[4:0]];
      if (ld_a)    dp_a    <= dp_dout;
      if (push) dp_sp <= dp_sp + 10'd1;
      else if (pop) begin
        dp_dout <= dp_stk[dp_sp - 10'd1];
        dp_sp   <= dp_sp - 10'd1;
      end
      if (tos) dp_dout <= dp_stk[dp_sp - 10'd1];
    end
  end

  // ---------------- instruction-level reference model ----------------
  mem_t       m_mem;
  logic [7:0] m_stk [1024];
  logic [4:0] m_pc;
  logic [9:0] m_sp;
  exp_t       sb[$];
  int         ret_cyc[$];

  function automatic int mem_sig(input mem_t mm);
    int s = 0;
    for (int i = 0; i < 32; i++) s += int'(mm[i]) * (i + 1);
    return s;
  endfunction

  function automatic logic [7:0] mpop();
    m_sp = m_sp - 10'd1;
    return m_stk[m_sp];
  endfunction

  function automatic void mpush(input logic [7:0] v);
    m_stk[m_sp] = v;
    m_sp = m_sp + 10'd1;
  endfunction

  task automatic isa_step();
    logic [7:0] ir, x, y, r;
    exp_t e;
    ir = m_mem[m_pc];
    m_pc = m_pc + 5'd1;
    e.op = ir[7:5];
    e.taken = 1'b0;
    case (ir[7:5])
      OP_ADD, OP_SUB, OP_AND: begin
        x = mpop();
        y = mpop();
        if (ir[7:5] == OP_ADD)      r = y + x;
        else if (ir[7:5] == OP_SUB) r = y - x;
        else                        r = y & x;
        mpush(r);
        e.len = 5;
      end
      OP_NOT:  begin x = mpop(); mpush(~x); e.len = 5; end
      OP_PUSH: begin mpush(m_mem[ir[4:0]]); e.len = 4; end
      OP_POP:  begin m_mem[ir[4:0]] = mpop(); e.len = 4; end
      OP_JMP:  begin m_pc = ir[4:0]; e.len = 3; end
      default: begin
        e.taken = (m_stk[m_sp - 10'd1] == 8'h00);
        if (e.taken) m_pc = ir[4:0];
        e.len = 5;
      end
    endcase
    e.pc = m_pc;
    e.sp = m_sp;
    e.tos_v = m_stk[m_sp - 10'd1];
    e.sig = mem_sig(m_mem);
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    int len = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (state == FETCH && ld_inst) len = 1;
      else if (state != FETCH) len++;
      if (retire) begin
        ret_cyc.push_back(cyc + 1);
        check("retire_has_expectation", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("instr_cycles", len, e.len);
          if (e.op == OP_JZ) check("jz_ld_pc", ld_pc, e.taken);
          @(posedge clk);
          #1;
          check("pc", dp_pc, e.pc);
          check("sp", dp_sp, e.sp);
          check("tos", dp_stk[dp_sp - 10'd1], e.tos_v);
          check("mem_sig", mem_sig(dp_mem), e.sig);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic load_and_model(input mem_t img, input int n, input bit run_at_reset);
    rst = 1'b1;
    run = run_at_reset;
    image = img;
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
    m_mem = img;
    for (int i = 0; i < 1024; i++) m_stk[i] = 8'h00;
    m_pc = '0;
    m_sp = '0;
    sb.delete();
    for (int i = 0; i < n; i++) isa_step();
    check("outputs_in_reset", outs, 22'h0);
    ret_cyc.delete();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_prog(input mem_t img, input int n, input int idle);
    int cnt = 0;
    load_and_model(img, n, idle == 0);
    if (idle > 0) begin
      for (int i = 0; i < idle; i++) begin
        @(negedge clk);
        check("idle_outputs", outs, 22'h0);
        check("idle_pc", dp_pc, 5'd0);
      end
      @(posedge clk);
      #1 run = 1'b1;
      @(posedge clk);
      #1 check("first_fetch_to_decode", state, DECODE);
    end
    for (int c = 0; c < n * 6 + 10 && cnt < n; c++) begin
      @(negedge clk);
      if (retire) begin
        cnt++;
        if (cnt == n) run = 1'b0;
      end
    end
    run = 1'b0;
    check("instructions_retired", cnt, n);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  function automatic mem_t blank();
    mem_t m;
    for (int i = 0; i < 32; i++) m[i] = 8'h00;
    return m;
  endfunction

  initial begin
    mem_t p;
    int exp_ret [7] = '{4, 8, 13, 17, 21, 26, 31};
    bit found;

    // push 6, push 8, ADD, push 3, push 6, ADD, SUB -> 0x05
    p = blank();
    p[24] = 8'h06; p[25] = 8'h08; p[26] = 8'h03;
    p[0] = 8'h98; p[1] = 8'h99; p[2] = 8'h00; p[3] = 8'h9A;
    p[4] = 8'h98; p[5] = 8'h00; p[6] = 8'h20;
    run_prog(p, 7, 0);
    check("p1_tos", dp_stk[dp_sp - 10'd1], 8'h05);
    check("p1_retire_count", ret_cyc.size(), 7);
    for (int i = 0; i < 7 && i < ret_cyc.size(); i++) check("p1_retire_cycle", ret_cyc[i], exp_ret[i]);

    // push 0x06, NOT, POP 20 -> mem[20] = 0xF9
    p = blank();
    p[24] = 8'h06;
    p[0] = 8'h98; p[1] = 8'h60; p[2] = 8'hB4;
    run_prog(p, 3, 0);
    check("p2_mem20", dp_mem[20], 8'hF9);
    check("p2_sp", dp_sp, 10'd0);

    // push 0, JZ 10 -> taken; also exercises run held low after reset
    p = blank();
    p[24] = 8'h00;
    p[0] = 8'h98; p[1] = 8'hEA;
    run_prog(p, 2, 10);
    check("p3_pc", dp_pc, 5'd10);
    check("p3_tos", dp_stk[dp_sp - 10'd1], 8'h00);
    check("p3_sp", dp_sp, 10'd1);

    // push 4, JZ 10 -> not taken
    p[24] = 8'h04;
    run_prog(p, 2, 0);
    check("p4_pc", dp_pc, 5'd2);

    // reset in the EXEC cycle of ADD, then re-run from PC 0
    p = blank();
    p[24] = 8'h06; p[25] = 8'h08; p[26] = 8'h03;
    p[0] = 8'h98; p[1] = 8'h99; p[2] = 8'h00; p[3] = 8'h9A;
    p[4] = 8'h98; p[5] = 8'h00; p[6] = 8'h20;
    load_and_model(p, 2, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clk);
      #1 if (state == EXEC) found = 1'b1;
    end
    check("reached_exec", found, 1'b1);
    rst = 1'b1;
    #1 check("abort_outputs", outs, 22'h0);
    repeat (2) @(negedge clk);
    check("abort_drained", sb.size(), 0);
    run_prog(p, 7, 0);
    check("rerun_tos", dp_stk[dp_sp - 10'd1], 8'h05);

    // randomized programs
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 32; i++) p[i] = 8'($urandom);
      run_prog(p, 30, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
